// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin owner of a shared 4:1 mux (in: clk, reset_n, req[3:0], in0-in3; out: grant[3:0], sel[1:0], out_valid, out)
module mux4_rr_arbiter #(
  parameter int nbits = 8,
  parameter int max_hold = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       req,
  input  logic [nbits-1:0] in0,
  input  logic [nbits-1:0] in1,
  input  logic [nbits-1:0] in2,
  input  logic [nbits-1:0] in3,
  output logic [3:0]       grant,
  output logic [1:0]       sel,
  output logic             out_valid,
  output logic [nbits-1:0] out
);
  localparam int hw = $clog2(max_hold) + 1;
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [1:0] ptr, ptr_n, sel_n, win;
  logic [2:0] rot;
  logic [3:0] grant_n;
  logic [hw-1:0] hold_cnt, hold_n;
  logic keep, any;
  assign rot = 3'({req, req} >> ptr);
  assign win = ptr + (rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3);
  assign any = |req;
  assign keep = state == GRANT && req[sel] && hold_cnt < hw'(max_hold - 1);
  always_comb begin
    state_n = (keep || any) ? GRANT : IDLE;
    grant_n = keep ? grant : any ? 4'(1) << win : 4'd0;
    sel_n = (keep || !any) ? sel : win;
    ptr_n = (keep || !any) ? ptr : win + 2'd1;
    hold_n = keep ? hold_cnt + hw'(1) : '0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      grant <= '0;
      sel <= '0;
      ptr <= '0;
      hold_cnt <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      sel <= sel_n;
      ptr <= ptr_n;
      hold_cnt <= hold_n;
    end
  end
  assign out_valid = state == GRANT;
  assign out = sel[1] ? (sel[0] ? in3 : in2) : (sel[0] ? in1 : in0);
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed and random checks of mux4_rr_arbiter against a tenure model
module tb_mux4_rr_arbiter;
  localparam int mh = 4;
  logic clk = 0;
  logic reset_n = 1;
  logic [3:0] req = '0;
  logic [7:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic [3:0] grant;
  logic [1:0] sel;
  logic out_valid;
  logic [7:0] out;
  int errors = 0;
  int checks = 0;
  int m_owner, m_ptr, m_cnt, m_sel;

  mux4_rr_arbiter #(.nbits(8), .max_hold(mh)) dut (
    .clk(clk), .reset_n(reset_n), .req(req),
    .in0(d0), .in1(d1), .in2(d2), .in3(d3),
    .grant(grant), .sel(sel), .out_valid(out_valid), .out(out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pick(int i);
    return i == 0 ? d0 : i == 1 ? d1 : i == 2 ? d2 : d3;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_cnt = 0; m_sel = 0;
  endtask

  // An owner keeps the bus while it asks and its tenure is short of mh cycles;
  // otherwise the first requester at or after ptr takes over.
  task automatic model_edge(logic [3:0] r);
    int w;
    if (m_owner >= 0 && r[m_owner] && m_cnt < mh - 1) m_cnt++;
    else begin
      w = -1;
      for (int i = 0; i < 4; i++)
        if (w < 0 && r[(m_ptr + i) % 4]) w = (m_ptr + i) % 4;
      m_owner = w;
      m_cnt = 0;
      if (w >= 0) begin m_sel = w; m_ptr = (w + 1) % 4; end
    end
  endtask

  task automatic check_all(string tag);
    check({tag, ".grant"}, 32'(grant), m_owner >= 0 ? 32'(1) << m_owner : 32'd0);
    check({tag, ".sel"}, 32'(sel), 32'(m_sel));
    check({tag, ".valid"}, 32'(out_valid), 32'(m_owner >= 0));
    check({tag, ".out"}, 32'(out), 32'(pick(m_sel)));
  endtask

  task automatic step(logic [3:0] r, string tag);
    req = r;
    d0 = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom); d3 = 8'($urandom);
    @(posedge clk);
    model_edge(r);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    reset_n = 0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    reset_n = 1;
  endtask

  initial begin
    model_reset();
    #1;
    reset_n = 0;
    @(posedge clk);
    #1;
    check_all("por");
    @(negedge clk);
    reset_n = 1;
    step(4'b0000, "idle");
    step(4'b0100, "single");
    d2 = 8'hA5;
    #1;
    check("single.a5", 32'(out), 32'hA5);
    check("single.grant", 32'(grant), 32'b0100);
    step(4'b0000, "drop");
    step(4'b0100, "regrant");
    step(4'b0100, "regrant2");
    #2;
    do_reset();
    check("midreset.grant", 32'(grant), 32'd0);
    for (int c = 0; c < 20; c++) begin
      step(4'b1111, "contend");
      check("contend.seq", 32'(grant), 32'(1) << ((c / 4) % 4));
      check("contend.valid", 32'(out_valid), 32'd1);
    end
    step(4'b0000, "gap");
    step(4'b1010, "early");
    step(4'b1010, "early");
    step(4'b1000, "early.drop");
    check("early.next", 32'(grant), 32'b1000);
    step(4'b0000, "gap2");
    for (int c = 0; c < 10; c++) begin
      step(4'b0001, "sole");
      check("sole.grant", 32'(grant), 32'b0001);
    end
    step(4'b0000, "gap3");
    do_reset();
    step(4'b0100, "nopre");
    for (int c = 0; c < 3; c++) begin
      step(4'b0101, "nopre.hold");
      check("nopre.grant", 32'(grant), 32'b0100);
    end
    step(4'b0101, "nopre.rel");
    check("nopre.next", 32'(grant), 32'b0001);
    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(0, 40) == 0) begin
        #2;
        do_reset();
      end
      step(4'($urandom), "rand");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
